aes_inv_key_schedule: RTL and testbench
=======================================

Name: aes_inv_key_schedule

Overview:
Iterative AES-128 inverse key expansion for the decryption datapath. It accepts the final (round-10) round key and streams round keys 10 down to 0, one per accepted beat. The keys arrive in the order the inverse cipher's AddRoundKey stage needs them. The block holds a single 128-bit key register and computes the previous round key on the fly, so no 11-entry key RAM is needed.

Parameters:
NR, 10, number of AES rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start_valid  input  1  request to begin a schedule
start_ready  output  1  block idle, can accept start
last_key  input  128  round-10 key, w0 in [127:96], w3 in [31:0]; sampled on start handshake
rk_valid  output  1  rk_key/rk_index valid
rk_ready  input  1  downstream accepts current round key
rk_key  output  128  current round key, same word/byte packing as last_key
rk_index  output  4  round number of rk_key (10..0)
rk_last  output  1  high with the round-0 beat (rk_index == 0)
busy  output  1  schedule in progress

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, rk_valid=0, rk_key=0, rk_index=0, rk_last=0, busy=0, start_ready=1 after reset. Reset mid-schedule aborts with no further beats.
- FSM states: IDLE and EMIT.
- start_ready = (state==IDLE); busy = (state==EMIT); rk_valid = (state==EMIT); rk_last = rk_valid && rk_index==0.
- IDLE: on start_valid&&start_ready, key_reg<=last_key, idx<=10, go to EMIT. start_valid without ready has no effect.
- EMIT: rk_key=key_reg and rk_index=idx, both registered. They stay stable while rk_valid && !rk_ready. On rk_ready:
  - idx==0: go to IDLE.
  - otherwise: key_reg<=prev(key_reg), idx<=idx-1.
- Latency: start accepted at cycle T gives the first beat (index 10) valid at T+1. With rk_ready held high, indices 10..0 appear at T+1..T+11, the block is IDLE at T+12, and the next start can be accepted at T+12. start_valid asserted during EMIT is ignored and must be held by the requester.
- prev() math: input words {w0,w1,w2,w3} for round r. Output:
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
- RotWord({a0,a1,a2,a3}) = {a1,a2,a3,a0}, with a0 the MSB byte. SubWord applies the forward AES S-box to each of the 4 bytes.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, indexed by the current idx before decrement.
- S-box: internal 256-entry constant table, 4 parallel lookups, purely combinational within the cycle. The block has no multicycle paths.
- The block contains no state besides FSM, key_reg (128), and idx (4).

Test Plan:
- Reset, then start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 and rk_ready=1 -> 11 beats on consecutive cycles:
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - idx9 = ac7766f319fadc2128d12941575c006e
  - idx5 = d4d1c6f87c839d87caf2b8bc11f915bc
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx0 = 2b7e151628aed2a6abf7158809cf4f3c with rk_last=1
  - start_ready=1 the cycle after the idx0 beat.
- Same vector with rk_ready randomly toggled ~50% -> identical key sequence; rk_key/rk_index never change while rk_valid&&!rk_ready; exactly 11 handshakes.
- Random 128-bit key K run through the bench's forward AES-128 expansion model; round-10 key fed in -> all 11 streamed keys match the model, and idx0 == K. Repeat for 50 keys.
- start_valid pulsed during EMIT with a different last_key -> ignored, current sequence unchanged. After the idx0 beat, a held start_valid is accepted exactly at start_ready=1.
- rst_n low for one cycle while rk_index==6 -> next cycle rk_valid=0, busy=0, start_ready=1. A new start then produces a full fresh sequence from index 10.
- Back-to-back schedules with start_valid held high and rk_ready=1 -> second schedule's index-10 beat appears 2 cycles after the first schedule's index-0 beat.

Source files
------------

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: loads the round-10 key and streams round keys
// 10 down to 0, deriving each previous key on the fly from a single key register.
module aes_inv_key_schedule #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [127:0] last_key,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_key,
   output logic [3:0]   rk_index,
   output logic         rk_last,
   output logic         busy
);

   // Only the 10-round (128-bit key) schedule exists in this datapath.
   if (NR != 10) begin : g_nr_check
      $error("aes_inv_key_schedule supports only NR == 10");
   end

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Forward AES S-box; RotWord/SubWord of the inverse step uses the forward table.
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   state_t         state_reg;
   logic [127:0]   key_reg;
   logic [3:0]     idx_reg;

   logic [31:0]    w0, w1, w2, w3;
   logic [31:0]    p3;
   logic [31:0]    rot_word;
   logic [31:0]    sub_word;
   logic [7:0]     rcon;
   logic [127:0]   key_next;

   assign w0 = key_reg[127:96];
   assign w1 = key_reg[95:64];
   assign w2 = key_reg[63:32];
   assign w3 = key_reg[31:0];

   // Previous round's last word is recovered first; it feeds the g() function for w0.
   assign p3       = w3 ^ w2;
   assign rot_word = {p3[23:0], p3[31:24]};

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_word[8*gi +: 8] = SBOX[rot_word[8*gi +: 8]];
   end

   // Round constant belongs to the round being undone, i.e. the current index.
   always_comb begin
      rcon = 8'h00;
      case (idx_reg)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign key_next = {w0 ^ sub_word ^ {rcon, 24'h000000}, w1 ^ w0, w2 ^ w1, p3};

   // Control FSM plus key/index registers; a handshake on rk_ready steps one round back.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         key_reg   <= '0;
         idx_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_valid) begin
                  key_reg   <= last_key;
                  idx_reg   <= 4'd10;
                  state_reg <= EMIT;
               end
            end
            EMIT: begin
               if (rk_ready) begin
                  if (idx_reg == 4'd0) begin
                     state_reg <= IDLE;
                  end else begin
                     key_reg <= key_next;
                     idx_reg <= idx_reg - 4'd1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign start_ready = (state_reg == IDLE);
   assign busy        = (state_reg == EMIT);
   assign rk_valid    = (state_reg == EMIT);
   assign rk_key      = key_reg;
   assign rk_index    = idx_reg;
   assign rk_last     = rk_valid && (idx_reg == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule against a forward AES-128 key
// expansion model built from GF(2^8) arithmetic.
module tb_aes_inv_key_schedule;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_valid;
   logic         start_ready;
   logic [127:0] last_key;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_key;
   logic [3:0]   rk_index;
   logic         rk_last;
   logic         busy;

   int errors = 0;
   int checks = 0;

   logic [127:0] ref_keys [0:10];
   logic [127:0] obs_keys [0:10];

   aes_inv_key_schedule #(.NR(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .last_key    (last_key),
      .rk_valid    (rk_valid),
      .rk_ready    (rk_ready),
      .rk_key      (rk_key),
      .rk_index    (rk_index),
      .rk_last     (rk_last),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Hard time limit so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box = affine transform of the multiplicative inverse (x^254).
   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [7:0] r = 8'h01;
      logic [7:0] base = x;
      for (int e = 254, i = 0; i < 8; i++) begin
         if (e[i]) r = gmul(r, base);
         base = gmul(base, base);
      end
      return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
   endfunction

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h000000};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [127:0] key);
      chk("start_ready_before_start", start_ready, 1);
      start_valid = 1'b1;
      last_key    = key;
      step();
      start_valid = 1'b0;
      chk("first_beat_valid", rk_valid, 1);
      chk("first_beat_index", rk_index, 10);
      chk("first_beat_key", rk_key, key);
   endtask

   // Consume one full schedule from the displayed index-10 beat; compares against ref_keys.
   task automatic stream(input bit rand_ready, input bit noise, output int beats);
      int          e = 10;
      int          guard = 0;
      bit          pstall = 1'b0;
      bit          rdy;
      logic [127:0] pk;
      logic [3:0]   pi;
      beats = 0;
      while (e >= 0 && guard < 300) begin
         if (pstall) begin
            chk("stall_key_stable", rk_key, pk);
            chk("stall_index_stable", rk_index, pi);
         end
         rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         rk_ready = rdy;
         if (noise) begin
            start_valid = 1'($urandom_range(0, 1));
            last_key    = {$urandom, $urandom, $urandom, $urandom};
         end
         if (rdy) begin
            chk("beat_valid", rk_valid, 1);
            chk("beat_index", rk_index, 128'(e));
            chk("beat_key", rk_key, ref_keys[e]);
            chk("beat_last", rk_last, (e == 0));
            $display("beat idx=%0d key=%h", rk_index, rk_key);
            obs_keys[e] = rk_key;
            beats++;
            e--;
         end
         pstall = !rdy;
         pk     = rk_key;
         pi     = rk_index;
         step();
         guard++;
      end
      if (guard >= 300) chk("stream_cycle_budget", 128'(guard), 128'(0));
      if (noise) start_valid = 1'b0;
      chk("after_idle_start_ready", start_ready, 1);
      chk("after_idle_busy", busy, 0);
      chk("after_idle_valid", rk_valid, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [127:0] k1;
      logic [127:0] k2;
      logic [127:0] k2_last;
      int           beats;
      int           g;

      rst_n = 1'b0; start_valid = 1'b0; last_key = '0; rk_ready = 1'b0;
      step(); step();
      chk("reset_valid", rk_valid, 0);
      chk("reset_key", rk_key, 0);
      chk("reset_index", rk_index, 0);
      chk("reset_last", rk_last, 0);
      chk("reset_busy", busy, 0);
      chk("reset_start_ready", start_ready, 1);
      rst_n = 1'b1;
      step();

      // Known FIPS-197 vector, ready held high.
      k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      expand(k1);
      do_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      stream(1'b0, 1'b0, beats);
      chk("fips_beats", 128'(beats), 11);
      chk("fips_idx9", obs_keys[9], 128'hac7766f319fadc2128d12941575c006e);
      chk("fips_idx5", obs_keys[5], 128'hd4d1c6f87c839d87caf2b8bc11f915bc);
      chk("fips_idx1", obs_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips_idx0", obs_keys[0], k1);

      // Same vector with random back-pressure.
      do_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      stream(1'b1, 1'b0, beats);
      chk("fips_bp_beats", 128'(beats), 11);

      // Random keys, random back-pressure, occasional start noise during EMIT.
      for (int n = 0; n < 50; n++) begin
         k1 = {$urandom, $urandom, $urandom, $urandom};
         expand(k1);
         do_start(ref_keys[10]);
         stream(1'($urandom_range(0, 1)), (n % 3 == 0), beats);
         chk("rand_beats", 128'(beats), 11);
         chk("rand_idx0_is_key", obs_keys[0], k1);
      end

      // Start held during EMIT with a different key: ignored, then accepted at IDLE.
      k2 = {$urandom, $urandom, $urandom, $urandom};
      expand(k2);
      k2_last = ref_keys[10];
      k1 = {$urandom, $urandom, $urandom, $urandom};
      expand(k1);
      do_start(ref_keys[10]);
      start_valid = 1'b1;
      last_key    = k2_last;
      stream(1'b1, 1'b0, beats);
      chk("held_first_beats", 128'(beats), 11);
      step();
      start_valid = 1'b0;
      chk("held_accept_valid", rk_valid, 1);
      chk("held_accept_index", rk_index, 10);
      chk("held_accept_key", rk_key, k2_last);
      expand(k2);
      stream(1'b0, 1'b0, beats);
      chk("held_second_idx0", obs_keys[0], k2);

      // Reset while index 6 is on the bus.
      k1 = {$urandom, $urandom, $urandom, $urandom};
      expand(k1);
      do_start(ref_keys[10]);
      rk_ready = 1'b1;
      g = 0;
      while (rk_index != 4'd6 && g < 20) begin
         step();
         g++;
      end
      chk("reach_index6", rk_index, 6);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_valid", rk_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_start_ready", start_ready, 1);
      k2 = {$urandom, $urandom, $urandom, $urandom};
      expand(k2);
      do_start(ref_keys[10]);
      stream(1'b0, 1'b0, beats);
      chk("post_abort_beats", 128'(beats), 11);
      chk("post_abort_idx0", obs_keys[0], k2);

      // Back-to-back schedules: index-10 beat two cycles after the index-0 beat.
      k1 = {$urandom, $urandom, $urandom, $urandom};
      expand(k1);
      start_valid = 1'b1;
      last_key    = ref_keys[10];
      rk_ready    = 1'b1;
      step();
      chk("b2b_first_index", rk_index, 10);
      stream(1'b0, 1'b0, beats);
      step();
      start_valid = 1'b0;
      chk("b2b_second_valid", rk_valid, 1);
      chk("b2b_second_index", rk_index, 10);
      chk("b2b_second_key", rk_key, ref_keys[10]);
      stream(1'b0, 1'b0, beats);
      chk("b2b_second_idx0", obs_keys[0], k1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
